// File: rtl/decoder_3to8_buf_if.sv
// Handshake and output bundle for decoder_3to8_buf.
// The master drives codes in and watches the decoded output; the slave is the decoder.
interface decoder_3to8_buf_if #(
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic          in_valid;
    logic          in_ready;
    logic [2:0]    in_code;
    logic [7:0]    out;
    logic          out_valid;
    logic [CW-1:0] count;
    logic          busy;
    logic          state_dbg;

    modport master (
        output in_valid, in_code,
        input  in_ready, out, out_valid, count, busy, state_dbg
    );

    modport slave (
        input  in_valid, in_code,
        output in_ready, out, out_valid, count, busy, state_dbg
    );
endinterface

// File: rtl/decoder_3to8_buf.sv
// Buffered 3-to-8 decoder: codes queue in a small FIFO and each is driven out
// as a registered one-hot byte held for HOLD cycles, back-to-back when more are queued.
module decoder_3to8_buf #(
    parameter int DEPTH = 4,
    parameter int HOLD  = 1
) (
    input logic               clk,
    input logic               rst,
    decoder_3to8_buf_if.slave bus
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int HW = (HOLD > 1) ? $clog2(HOLD) : 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [HW-1:0] HOLD_LD = HW'(HOLD - 1);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_HOLD = 1'b1
    } state_t;

    logic [2:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count_q;
    logic [HW-1:0] hold_cnt;
    logic [7:0]    out_q;
    logic          out_valid_q;
    state_t        state;

    logic          ready_w;
    logic          push;
    logic          pop;
    logic [2:0]    head;

    // in_valid/in_ready: a code transfers on any rising edge where both are high.
    // in_ready depends only on the registered count, so a pop never frees a slot
    // in the same cycle.
    assign ready_w = (count_q < DEPTH_C);
    assign push    = bus.in_valid && ready_w;
    assign pop     = (count_q != '0) && ((state == S_IDLE) || (hold_cnt == '0));
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= bus.in_code;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count_q     <= '0;
            hold_cnt    <= '0;
            out_q       <= 8'h00;
            out_valid_q <= 1'b0;
            state       <= S_IDLE;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase

            case (state)
                S_IDLE: begin
                    if (pop) begin
                        out_q       <= 8'h01 << head;
                        out_valid_q <= 1'b1;
                        hold_cnt    <= HOLD_LD;
                        state       <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (hold_cnt != '0) begin
                        hold_cnt <= hold_cnt - 1'b1;
                    end else if (pop) begin
                        // Next word follows with no idle cycle in between.
                        out_q    <= 8'h01 << head;
                        hold_cnt <= HOLD_LD;
                    end else begin
                        out_q       <= 8'h00;
                        out_valid_q <= 1'b0;
                        state       <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.in_ready  = ready_w;
    assign bus.out       = out_q;
    assign bus.out_valid = out_valid_q;
    assign bus.count     = count_q;
    assign bus.busy      = out_valid_q || (count_q != '0);
    assign bus.state_dbg = state;
endmodule
